// File: rtl/tx_filt_ctrl_if.sv
// ============================================================================
// Module   : tx_filt_ctrl_if
// Brief    : Host write / commit / sample-pacing bundle for tx_filt_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface tx_filt_ctrl_if #(
    parameter int NTAPS_UNIQ = 11,
    parameter int CW         = 18
);
    logic                         run;
    logic                         coef_wr_valid;
    logic                         coef_wr_ready;
    logic [3:0]                   coef_wr_addr;
    logic signed [CW-1:0]         coef_wr_data;
    logic                         coef_commit;
    logic                         samp_en;
    logic [NTAPS_UNIQ*CW-1:0]     coef_bank;
    logic                         swap_pend;
    logic                         swap_done;
    logic                         err_addr;

    modport master (
        output run,
        output coef_wr_valid,
        output coef_wr_addr,
        output coef_wr_data,
        output coef_commit,
        input  coef_wr_ready,
        input  samp_en,
        input  coef_bank,
        input  swap_pend,
        input  swap_done,
        input  err_addr
    );

    modport slave (
        input  run,
        input  coef_wr_valid,
        input  coef_wr_addr,
        input  coef_wr_data,
        input  coef_commit,
        output coef_wr_ready,
        output samp_en,
        output coef_bank,
        output swap_pend,
        output swap_done,
        output err_addr
    );
endinterface

`default_nettype wire

// File: rtl/tx_filt_ctrl.sv
// ============================================================================
// Module   : tx_filt_ctrl
// Brief    : Sample-rate scheduler and shadow/active coefficient bank for the
//            21-tap symmetric TX FIR. Optional macro TX_FILT_CTRL_IMPULSE_EN
//            makes the active bank reset to a centre-tap impulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tx_filt_ctrl #(
    parameter int NTAPS_UNIQ = 11,
    parameter int CW         = 18,
    parameter int DIV        = 4
) (
    input  wire logic      clk,
    input  wire logic      reset,
    tx_filt_ctrl_if.slave  bus
);

    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_RUN   = 2'd1;
    localparam logic [1:0]  c_ST_PEND  = 2'd2;
    localparam logic [3:0]  c_CNT_LAST = 4'(DIV - 1);
    localparam logic [31:0] c_NTAPS    = 32'(NTAPS_UNIQ);
`ifdef TX_FILT_CTRL_IMPULSE_EN
    localparam logic signed [CW-1:0] c_CENTRE_RST = {1'b0, {(CW-1){1'b1}}};
`else
    localparam logic signed [CW-1:0] c_CENTRE_RST = '0;
`endif

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [3:0]           cnt_q;
    logic [3:0]           cnt_d;
    logic [3:0]           w_cnt_inc;
    logic                 w_swap;
    logic                 w_samp_en;
    logic                 w_wr_ready;
    logic                 w_swap_pend;
    logic                 w_wr_fire;
    logic                 w_addr_ok;
    logic                 w_wr_hit;
    logic                 w_wr_bad;
    logic                 swap_done_q;
    logic                 err_addr_q;

    logic signed [CW-1:0] shadow_q [NTAPS_UNIQ];
    logic signed [CW-1:0] shadow_d [NTAPS_UNIQ];
    logic signed [CW-1:0] active_q [NTAPS_UNIQ];

    assign w_cnt_inc = (cnt_q == c_CNT_LAST) ? 4'd0 : cnt_q + 4'd1;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= c_ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state, counter and swap decision
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_swap  = 1'b0;
        case (state_q)
            c_ST_IDLE: begin
                cnt_d  = 4'd0;
                w_swap = bus.coef_commit;
                if (bus.run) begin
                    state_d = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (!bus.run) begin
                    // Leaving pacing: a commit here has no boundary to wait for.
                    state_d = c_ST_IDLE;
                    cnt_d   = 4'd0;
                    w_swap  = bus.coef_commit;
                end else begin
                    cnt_d = w_cnt_inc;
                    if (bus.coef_commit) begin
                        state_d = c_ST_PEND;
                    end
                end
            end
            c_ST_PEND: begin
                if (!bus.run) begin
                    state_d = c_ST_IDLE;
                    cnt_d   = 4'd0;
                    w_swap  = 1'b1;
                end else begin
                    cnt_d = w_cnt_inc;
                    if (w_samp_en) begin
                        state_d = c_ST_RUN;
                        w_swap  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = c_ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs, decoded from registers only
    // ------------------------------------------------------------------------
    always_comb begin
        w_samp_en   = (state_q != c_ST_IDLE) && (cnt_q == c_CNT_LAST);
        w_wr_ready  = (state_q != c_ST_PEND);
        w_swap_pend = (state_q == c_ST_PEND);
    end

    assign w_wr_fire = bus.coef_wr_valid && w_wr_ready;
    assign w_addr_ok = ({28'd0, bus.coef_wr_addr} < c_NTAPS);
    assign w_wr_hit  = w_wr_fire && w_addr_ok;
    assign w_wr_bad  = w_wr_fire && !w_addr_ok;

    // Shadow after this cycle's write; the swap copies this so a same-cycle
    // write and commit land together.
    always_comb begin
        shadow_d = shadow_q;
        if (w_wr_hit) begin
            shadow_d[bus.coef_wr_addr] = bus.coef_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NTAPS_UNIQ; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= (i == NTAPS_UNIQ - 1) ? c_CENTRE_RST : '0;
            end
            swap_done_q <= 1'b0;
            err_addr_q  <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            if (w_swap) begin
                active_q <= shadow_d;
            end
            swap_done_q <= w_swap;
            err_addr_q  <= w_wr_bad;
        end
    end

    for (genvar gi = 0; gi < NTAPS_UNIQ; gi++) begin : g_bank
        assign bus.coef_bank[gi*CW +: CW] = active_q[gi];
    end

    assign bus.samp_en       = w_samp_en;
    assign bus.coef_wr_ready = w_wr_ready;
    assign bus.swap_pend     = w_swap_pend;
    assign bus.swap_done     = swap_done_q;
    assign bus.err_addr      = err_addr_q;

endmodule

`default_nettype wire
